sonar_filter: RTL and testbench

SONAR_FILTER -- requirements
Module: sonar_filter

---
 rtl/sonar_pkg.sv | 23 ++
 rtl/sonar_filter_median3.sv | 21 ++
 rtl/sonar_filter.sv | 127 ++++++++++++
 tb/tb_sonar_filter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sonar_pkg.sv
// Shared defaults, FSM encoding and small helpers for the sonar range filter.
package sonar_pkg;

    localparam int unsigned SONAR_MIN_US     = 882;
    localparam int unsigned SONAR_MAX_US     = 37500;
    localparam int unsigned SONAR_TIMEOUT_US = 100000;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_VALID = 2'd1;
    localparam logic [1:0] ST_STALE = 2'd2;

    // h0 is the newest sample
    typedef struct packed {
        logic [15:0] h0;
        logic [15:0] h1;
        logic [15:0] h2;
    } hist_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sonar_filter_median3.sv
// Combinational median of three unsigned 16-bit values.
module median3 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic [15:0] c_i,
    output logic [15:0] med_o
);

    logic [15:0] lo;
    logic [15:0] hi;
    logic [15:0] mid;

    // median = max(min(a,b), min(max(a,b),c)); ties fall out naturally
    always_comb begin
        lo    = (a_i < b_i) ? a_i : b_i;
        hi    = (a_i < b_i) ? b_i : a_i;
        mid   = (hi < c_i) ? hi : c_i;
        med_o = (lo > mid) ? lo : mid;
    end

endmodule

// File: rtl/sonar_filter.sv
// Sonar pulse-width filter: range gating, 3-tap median, staleness timeout and
// a saturating reject counter.
module sonar_filter
    import sonar_pkg::*;
#(
    parameter int unsigned MIN_US     = SONAR_MIN_US,
    parameter int unsigned MAX_US     = SONAR_MAX_US,
    parameter int unsigned TIMEOUT_US = SONAR_TIMEOUT_US
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        us_tick,
    input  logic        en,
    input  logic [15:0] sonar_data,
    input  logic        data_vld,
    output logic [15:0] range_us,
    output logic        range_vld,
    output logic        range_ok,
    output logic        timeout,
    output logic [7:0]  err_cnt
);

    localparam logic [15:0] MIN_W = 16'(MIN_US);
    localparam logic [15:0] MAX_W = 16'(MAX_US);
    localparam logic [16:0] TERM  = 17'(TIMEOUT_US - 1);

    hist_t       hist_q, hist_d;
    logic [1:0]  fill_q, fill_d;
    logic        calc_q, calc_d;
    logic [16:0] cnt_q, cnt_d;
    logic [1:0]  state_q, state_d;
    logic [15:0] range_q, range_d;
    logic        vld_q, vld_d;
    logic [7:0]  err_q, err_d;

    logic        in_range;
    logic        sample_ok;
    logic        sample_bad;
    logic        expire;
    logic [1:0]  fill_inc;
    logic [15:0] med;

    median3 u_median3 (
        .a_i   (hist_q.h0),
        .b_i   (hist_q.h1),
        .c_i   (hist_q.h2),
        .med_o (med)
    );

    assign in_range   = (sonar_data >= MIN_W) && (sonar_data <= MAX_W);
    assign sample_ok  = data_vld && en && in_range;
    assign sample_bad = data_vld && en && !in_range;
    assign expire     = en && us_tick && (cnt_q == TERM) && !sample_ok;
    assign fill_inc   = (fill_q == 2'd3) ? 2'd3 : fill_q + 2'd1;

    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        calc_d  = 1'b0;
        cnt_d   = cnt_q;
        state_d = state_q;
        range_d = range_q;
        vld_d   = 1'b0;
        err_d   = err_q;
        if (!en) begin
            // disabling flushes the pipeline too, so range_us keeps its value
            fill_d  = 2'd0;
            cnt_d   = '0;
            state_d = ST_EMPTY;
        end else begin
            if (sample_bad) begin
                err_d = sat_inc8(err_q);
            end
            // second pipeline stage: history registered last clock is now stable
            if (calc_q) begin
                range_d = med;
                vld_d   = 1'b1;
                if (state_q == ST_EMPTY) begin
                    state_d = ST_VALID;
                end
            end
            if (sample_ok) begin
                hist_d = '{h0: sonar_data, h1: hist_q.h0, h2: hist_q.h1};
                fill_d = fill_inc;
                calc_d = (fill_inc == 2'd3);
                cnt_d  = '0;
                if (state_q == ST_STALE) begin
                    state_d = ST_EMPTY;
                end
            end else if (expire) begin
                state_d = ST_STALE;
                fill_d  = 2'd0;
            end else if (us_tick) begin
                cnt_d = cnt_q + 17'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q  <= '0;
            fill_q  <= 2'd0;
            calc_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= ST_EMPTY;
            range_q <= '0;
            vld_q   <= 1'b0;
            err_q   <= '0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            calc_q  <= calc_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            range_q <= range_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    assign range_us  = range_q;
    assign range_vld = vld_q;
    assign range_ok  = (state_q == ST_VALID);
    assign timeout   = (state_q == ST_STALE);
    assign err_cnt   = err_q;

endmodule

// File: tb/tb_sonar_filter.sv
// Directed bench for sonar_filter: a vector table for the median/gating path plus
// hand-written sequences for timeout, expiry race, enable flush and reset.
module tb_sonar_filter;

    logic        clk;
    logic        rst;
    logic        us_tick;
    logic        en;
    logic [15:0] sonar_data;
    logic        data_vld;
    logic [15:0] range_us;
    logic        range_vld;
    logic        range_ok;
    logic        timeout;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;
    int vld_seen = 0;
    int vld_base;

    sonar_filter #(
        .MIN_US     (882),
        .MAX_US     (37500),
        .TIMEOUT_US (100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .us_tick    (us_tick),
        .en         (en),
        .sonar_data (sonar_data),
        .data_vld   (data_vld),
        .range_us   (range_us),
        .range_vld  (range_vld),
        .range_ok   (range_ok),
        .timeout    (timeout),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (range_vld) vld_seen++;
    end

    typedef struct {
        logic [15:0] data;
        logic        exp_vld;
        logic [15:0] exp_range;
        logic [7:0]  exp_err;
        logic        exp_ok;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // one-clock data strobe; returns just after the accepting edge
    task automatic send(input logic [15:0] d);
        sonar_data = d;
        data_vld   = 1'b1;
        tick();
        data_vld   = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{16'd1000,  1'b0, 16'd0,    8'd0, 1'b0};
        vecs[1]  = '{16'd3000,  1'b0, 16'd0,    8'd0, 1'b0};
        vecs[2]  = '{16'd2000,  1'b1, 16'd2000, 8'd0, 1'b1};
        vecs[3]  = '{16'd2000,  1'b1, 16'd2000, 8'd0, 1'b1};
        vecs[4]  = '{16'd5000,  1'b1, 16'd2000, 8'd0, 1'b1};
        vecs[5]  = '{16'd881,   1'b0, 16'd2000, 8'd1, 1'b1};
        vecs[6]  = '{16'd37501, 1'b0, 16'd2000, 8'd2, 1'b1};
        vecs[7]  = '{16'd882,   1'b1, 16'd2000, 8'd2, 1'b1};
        vecs[8]  = '{16'd37500, 1'b1, 16'd5000, 8'd2, 1'b1};
        vecs[9]  = '{16'd100,   1'b0, 16'd5000, 8'd3, 1'b1};
        vecs[10] = '{16'd900,   1'b1, 16'd900,  8'd3, 1'b1};
        vecs[11] = '{16'd900,   1'b1, 16'd900,  8'd3, 1'b1};

        // reset overrides en, data_vld and us_tick
        rst = 1'b1; en = 1'b1; data_vld = 1'b1; sonar_data = 16'd100; us_tick = 1'b1;
        repeat (3) tick();
        chk("rst_range_us", range_us, 0);
        chk("rst_range_vld", range_vld, 0);
        chk("rst_range_ok", range_ok, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_err_cnt", err_cnt, 0);
        data_vld = 1'b0; us_tick = 1'b0; rst = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) begin
            send(vecs[i].data);
            chk($sformatf("vec%0d_vld_early", i), range_vld, 0);
            tick();
            chk($sformatf("vec%0d_vld", i), range_vld, vecs[i].exp_vld);
            chk($sformatf("vec%0d_range", i), range_us, vecs[i].exp_range);
            chk($sformatf("vec%0d_err", i), err_cnt, vecs[i].exp_err);
            chk($sformatf("vec%0d_ok", i), range_ok, vecs[i].exp_ok);
            $display("vec %0d: data=%0d range_vld=%0d range_us=%0d err_cnt=%0d range_ok=%0d",
                     i, vecs[i].data, range_vld, range_us, err_cnt, range_ok);
        end

        // timeout from VALID: expiry on the 100th tick
        us_tick = 1'b1;
        repeat (99) tick();
        chk("to_99_timeout", timeout, 0);
        chk("to_99_ok", range_ok, 1);
        tick();
        us_tick = 1'b0;
        chk("to_100_timeout", timeout, 1);
        chk("to_100_ok", range_ok, 0);
        chk("to_100_range_held", range_us, 900);
        $display("timeout seq: timeout=%0d range_ok=%0d range_us=%0d", timeout, range_ok, range_us);

        // recovery from STALE needs three fresh samples
        vld_base = vld_seen;
        send(16'd1000);
        chk("stale_exit_timeout", timeout, 0);
        chk("stale_exit_ok", range_ok, 0);
        tick();
        send(16'd2000);
        tick();
        chk("refill_no_vld", vld_seen - vld_base, 0);
        send(16'd3000);
        tick();
        chk("refill_vld", range_vld, 1);
        chk("refill_range", range_us, 2000);
        chk("refill_ok", range_ok, 1);
        tick();
        chk("refill_vld_count", vld_seen - vld_base, 1);
        $display("refill seq: range_us=%0d range_ok=%0d", range_us, range_ok);

        // accepted sample on the exact expiry tick wins and clears the counter
        us_tick = 1'b1;
        repeat (99) tick();
        chk("race_pre_timeout", timeout, 0);
        send(16'd4000);
        chk("race_timeout", timeout, 0);
        chk("race_ok", range_ok, 1);
        tick();
        chk("race_vld", range_vld, 1);
        chk("race_range", range_us, 3000);
        repeat (98) tick();
        chk("race_cnt_cleared", timeout, 0);
        tick();
        us_tick = 1'b0;
        chk("race_reexpire", timeout, 1);
        $display("race seq: timeout=%0d range_us=%0d", timeout, range_us);

        // back to VALID, then drop en for one clock
        send(16'd1000);
        send(16'd1000);
        send(16'd1000);
        tick();
        chk("en_pre_ok", range_ok, 1);
        chk("en_pre_range", range_us, 1000);
        en = 1'b0; sonar_data = 16'd500; data_vld = 1'b1;
        tick();
        data_vld = 1'b0; en = 1'b1;
        chk("en_drop_ok", range_ok, 0);
        chk("en_drop_timeout", timeout, 0);
        chk("en_drop_range", range_us, 1000);
        chk("en_drop_err", err_cnt, 3);
        vld_base = vld_seen;
        send(16'd881);
        send(16'd37501);
        send(16'd882);
        send(16'd37500);
        tick();
        tick();
        chk("bounds_err", err_cnt, 5);
        chk("bounds_no_vld", vld_seen - vld_base, 0);
        chk("bounds_ok", range_ok, 0);
        send(16'd2000);
        tick();
        chk("fill2_vld", range_vld, 1);
        chk("fill2_range", range_us, 2000);
        $display("en/bounds seq: err_cnt=%0d range_us=%0d", err_cnt, range_us);

        // 300 back-to-back rejects saturate the error counter
        sonar_data = 16'd0; data_vld = 1'b1;
        repeat (300) tick();
        data_vld = 1'b0;
        chk("sat_err", err_cnt, 255);
        tick();
        chk("sat_err_hold", err_cnt, 255);
        chk("sat_ok", range_ok, 1);
        $display("saturation seq: err_cnt=%0d", err_cnt);

        // reset one clock after an accepted sample discards it
        send(16'd3000);
        rst = 1'b1;
        vld_base = vld_seen;
        tick();
        rst = 1'b0;
        chk("inflight_vld", range_vld, 0);
        chk("inflight_range", range_us, 0);
        chk("inflight_ok", range_ok, 0);
        chk("inflight_timeout", timeout, 0);
        chk("inflight_err", err_cnt, 0);
        tick();
        tick();
        chk("inflight_no_pulse", vld_seen - vld_base, 0);
        $display("reset seq: range_us=%0d err_cnt=%0d range_ok=%0d", range_us, err_cnt, range_ok);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
